// File: rtl/lc_key_store_if.sv
// Read request / readout stream channel of the lifecycle key store.
// master = key consumer, slave = key store.
interface lc_key_store_if #(
  parameter int AW     = 3,
  parameter int WORD_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [AW-1:0]     req_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic [WORD_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_err;

  modport master (
    output req_valid, req_addr, rd_ready,
    input  req_ready, rd_valid, rd_data, rd_last, rd_err
  );

  modport slave (
    input  req_valid, req_addr, rd_ready,
    output req_ready, rd_valid, rd_data, rd_last, rd_err
  );
endinterface

// File: rtl/lc_key_store.sv
// Lifecycle key store: DEPTH write-once, lockable WIDTH-bit entries with
// deterministic reset defaults. Reads are returned as a stream of WORD_W
// beats (least-significant word first) taken from a snapshot made when
// the request is accepted.
module lc_key_store #(
  parameter int          WIDTH  = 256,
  parameter int          DEPTH  = 6,
  parameter int          WORD_W = 64,
  parameter logic [31:0] SEED   = 32'h33a344a3,
  parameter int          AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  lc_key_store_if.slave     bus,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_err,
  input  logic              lock_en,
  input  logic [AW-1:0]     lock_addr,
  output logic [DEPTH-1:0]  lock_status
);

  localparam int BEATS = WIDTH / WORD_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, ERR = 2'd2} state_t;

  // Reset value of entry idx: zero for entry 0, otherwise a replicated
  // golden-ratio step from SEED (mod 2^32).
  function automatic logic [WIDTH-1:0] default_entry(input int idx);
    logic [31:0] word;
    if (idx == 0) begin
      return {WIDTH{1'b0}};
    end else begin
      word = SEED + 32'(idx) * 32'h9E3779B9;
      return {(WIDTH / 32){word}};
    end
  endfunction

  state_t            state_r, state_n;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [DEPTH-1:0]  prog_r;
  logic [DEPTH-1:0]  lock_r;
  logic [WIDTH-1:0]  shift_r, shift_n;
  logic [CW-1:0]     cnt_r, cnt_n;
  logic              rd_valid_r, rd_last_r, rd_err_r, req_ready_r;
  logic              valid_n, last_n, err_n, ready_n;
  logic              wr_err_r;

  logic              req_in_range, wr_in_range, lock_in_range;
  logic [AW-1:0]     req_idx, wr_idx, lock_idx;
  logic              wr_ok, lock_ok;

  assign bus.req_ready = req_ready_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.rd_data   = shift_r[WORD_W-1:0];
  assign bus.rd_last   = rd_last_r;
  assign bus.rd_err    = rd_err_r;
  assign wr_err        = wr_err_r;
  assign lock_status   = lock_r;

  // Address range checks and program/lock eligibility against current flags.
  always_comb begin
    req_in_range  = ({1'b0, bus.req_addr} < DEPTH_V);
    wr_in_range   = ({1'b0, wr_addr} < DEPTH_V);
    lock_in_range = ({1'b0, lock_addr} < DEPTH_V);
    req_idx  = req_in_range  ? bus.req_addr : {AW{1'b0}};
    wr_idx   = wr_in_range   ? wr_addr      : {AW{1'b0}};
    lock_idx = lock_in_range ? lock_addr    : {AW{1'b0}};
    wr_ok    = wr_en && wr_in_range && (wr_addr != {AW{1'b0}}) &&
               !prog_r[wr_idx] && !lock_r[wr_idx];
    lock_ok  = lock_en && lock_in_range;
  end

  // Read FSM next-state and next registered output values.
  always_comb begin
    state_n = state_r;
    shift_n = shift_r;
    cnt_n   = cnt_r;
    valid_n = rd_valid_r;
    last_n  = rd_last_r;
    err_n   = rd_err_r;
    ready_n = req_ready_r;
    case (state_r)
      IDLE: begin
        valid_n = 1'b0;
        last_n  = 1'b0;
        err_n   = 1'b0;
        ready_n = 1'b1;
        shift_n = {WIDTH{1'b0}};
        cnt_n   = {CW{1'b0}};
        if (bus.req_valid && req_ready_r) begin
          ready_n = 1'b0;
          valid_n = 1'b1;
          if (!req_in_range || lock_r[req_idx]) begin
            state_n = ERR;
            last_n  = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = STREAM;
            shift_n = mem_r[req_idx];
            last_n  = (LAST_CNT == {CW{1'b0}});
          end
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        if (bus.rd_ready) begin
          if (cnt_r == LAST_CNT) begin
            state_n = IDLE;
            valid_n = 1'b0;
            last_n  = 1'b0;
            err_n   = 1'b0;
            ready_n = 1'b1;
            shift_n = {WIDTH{1'b0}};
            cnt_n   = {CW{1'b0}};
          end else begin
            cnt_n   = cnt_r + CNT_ONE;
            shift_n = shift_r >> WORD_W;
            last_n  = ((cnt_r + CNT_ONE) == LAST_CNT);
          end
        end else begin
          state_n = STREAM;
        end
      end
      ERR: begin
        if (bus.rd_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
          last_n  = 1'b0;
          err_n   = 1'b0;
          ready_n = 1'b1;
          shift_n = {WIDTH{1'b0}};
        end else begin
          state_n = ERR;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        last_n  = 1'b0;
        err_n   = 1'b0;
        ready_n = 1'b1;
        shift_n = {WIDTH{1'b0}};
        cnt_n   = {CW{1'b0}};
      end
    endcase
  end

  // Read FSM state, snapshot buffer and registered readout outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      shift_r     <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_last_r   <= 1'b0;
      rd_err_r    <= 1'b0;
      req_ready_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      shift_r     <= shift_n;
      cnt_r       <= cnt_n;
      rd_valid_r  <= valid_n;
      rd_last_r   <= last_n;
      rd_err_r    <= err_n;
      req_ready_r <= ready_n;
    end
  end

  // Entry storage, programmed/lock flags and program-reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= default_entry(i);
      end
      prog_r   <= {DEPTH{1'b0}};
      lock_r   <= {DEPTH{1'b0}};
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_en && !wr_ok;
      if (wr_ok) begin
        mem_r[wr_idx]  <= wr_data;
        prog_r[wr_idx] <= 1'b1;
      end
      if (lock_ok) begin
        lock_r[lock_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/lc_key_store.md
# lc_key_store

Parametrised successor to the lifecycle ROM. It holds DEPTH lifecycle/key entries of WIDTH bits, each loaded with a deterministic default on reset. Entries are write-once programmable and lockable per entry. Reads use a valid/ready request and are returned as a multi-beat stream of WORD_W-bit beats. The block sits between the lifecycle controller (programming and locking) and the key consumers (readout).

## Interface
- WIDTH, 256: entry width in bits; must be a multiple of 32 and of WORD_W.
- DEPTH, 6: number of entries; must be at least 2.
- WORD_W, 64: readout beat width; BEATS = WIDTH/WORD_W.
- SEED, 32'h33a344a3: base value for the default pattern.
- AW, $clog2(DEPTH): address width (derived; must not be overridden).

Ports:
- clk  in  1  clock; every transition happens on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  read request valid.
- req_ready  out  1  read request accepted when high together with req_valid.
- req_addr  in  AW  read address.
- rd_valid  out  1  readout beat valid.
- rd_ready  in  1  consumer accepts beat.
- rd_data  out  WORD_W  readout beat.
- rd_last  out  1  final beat of the response.
- rd_err  out  1  error response (locked entry or address out of range).
- wr_en  in  1  program request, single cycle.
- wr_addr  in  AW  program address.
- wr_data  in  WIDTH  program data.
- wr_err  out  1  one-cycle pulse when a program request is rejected.
- lock_en  in  1  lock request, single cycle.
- lock_addr  in  AW  lock address.
- lock_status  out  DEPTH  per-entry lock flags.

## Operation
- Reset (rst=1 on a clock edge) applies the following:
  - entry 0 = 0;
  - entry i (i≥1) = {WIDTH/32{SEED + i*32'h9E3779B9}}, using mod-2^32 arithmetic;
  - all programmed flags and lock flags are cleared;
  - the FSM goes to IDLE;
  - outputs become req_ready=0 during reset then 1, rd_valid=0, rd_data=0, rd_last=0, rd_err=0, wr_err=0, lock_status=0.
- Reset mid-stream aborts the response immediately. No further beats are issued.
- FSM:
  - IDLE: req_ready=1. A req_valid&req_ready handshake captures req_addr.
    - If the address is ≥DEPTH or the entry is locked, go to ERR.
    - Otherwise snapshot the entry into the shift buffer, clear the beat counter and go to STREAM.
  - STREAM: rd_valid=1 and rd_data = the current beat, with the least-significant word first. On a rd_ready handshake the counter increments. rd_last=1 when counter = BEATS-1. A handshake on the last beat returns to IDLE.
  - ERR: one beat with rd_valid=1, rd_data=0, rd_err=1, rd_last=1. A handshake returns to IDLE.
- rd_data, rd_last and rd_err hold stable while rd_valid=1 and rd_ready=0. They are 0 whenever rd_valid=0.
- The snapshot is taken at acceptance. Writes and locks that land during STREAM do not alter beats already in flight.
- Program: wr_en is rejected, with wr_err=1 on the next cycle and no state change, when any of these holds:
  - wr_addr=0 (entry 0 is permanently read-only);
  - wr_addr ≥ DEPTH;
  - the entry is already programmed;
  - the entry is locked.
  
  Otherwise the entry is loaded with wr_data and its programmed flag is set.
- Lock: lock_en with lock_addr < DEPTH sets the lock flag; the flag is sticky until reset. Out-of-range lock_addr is ignored. Locking an already-locked entry has no effect.
- Write and lock to the same address in the same cycle: the write is checked against the flags from before that edge, so it succeeds if eligible, and the lock is also applied.
- Write, lock and read handshakes can all occur in the same cycle. A read accepted in that cycle sees the entry contents and lock flags from before the edge.

## Timing
- Request accepted at edge N gives the first beat (rd_valid=1) after edge N; the registered output is visible in cycle N+1.
- A full response with rd_ready held at 1 takes BEATS cycles. An error response takes 1 cycle.
- The last-beat handshake at edge M returns the FSM to IDLE, so req_ready=1 in cycle M+1. There is no back-to-back overlap and at most one request is outstanding.
- wr_err and lock_status are registered and appear one cycle after the request. A written value is readable by a request accepted on the following edge.

## Test plan
- Reset, then read entry 1 with rd_ready=1 -> 4 beats of 64'hD1DABE5C_D1DABE5C, rd_last on beat 4, rd_err=0; req_ready=1 the cycle after beat 4.
- Read entry 0 with rd_ready toggling 1,0,1,0 -> 4 beats of 0; rd_data and rd_last hold stable while rd_ready=0.
- Write entry 3 with 256'hA5…A5, then write entry 3 again, then write entry 0 -> the second and third writes each pulse wr_err=1 one cycle later; reading entry 3 returns 4×64'hA5A5A5A5A5A5A5A5.
- Lock entry 2 -> lock_status=6'b000100. Reading entry 2 gives one beat with rd_err=1, rd_data=0, rd_last=1. Reading address 7 gives the same error response.
- Start a read of entry 4, then lock and write entry 4 during beat 2 -> all 4 beats carry the default value; a later read errors.
- Assert rst during beat 2 of a read -> rd_valid=0 next cycle; contents return to defaults (a programmed entry reverts) and lock_status=0.
